// File: rtl/lowx_mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// lowx_mem_arbiter_pkg
// Shared types for the lower-level memory arbiter: the owner and FSM state
// enums, the default bus widths, and the latched-transaction record.
// -----------------------------------------------------------------------------
package lowx_mem_arbiter_pkg;

  localparam int LOWX_XLEN     = 32;
  localparam int LOWX_BLK_SIZE = 128;

  typedef enum logic {
    ARB_IC = 1'b0,
    ARB_DC = 1'b1
  } arb_owner_e;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2
  } arb_state_e;

  // One granted request, frozen for the whole transaction.
  typedef struct packed {
    logic [LOWX_XLEN-1:0]     addr;
    logic                     rw;
    logic [LOWX_BLK_SIZE-1:0] data;
    logic                     uncached;
    arb_owner_e               owner;
  } lowx_txn_t;

  function automatic arb_owner_e other_side(input arb_owner_e side);
    return (side == ARB_IC) ? ARB_DC : ARB_IC;
  endfunction

endpackage

// File: rtl/lowx_mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// lowx_mem_arbiter_if
// Bundles the three buses around the arbiter:
//   ic_*  : I-cache miss path (read only)
//   dc_*  : D-cache miss / writeback / uncached path
//   mem_* : single downstream memory port
//   busy_o, timeout_err_o : status
// Modports:
//   master : the arbiter view (drives readies, responses, mem requests)
//   slave  : the surrounding environment (caches and memory adapter)
// -----------------------------------------------------------------------------
interface lowx_mem_arbiter_if #(
  parameter int XLEN     = 32,
  parameter int BLK_SIZE = 128
);

  logic                ic_req_valid_i;
  logic [XLEN-1:0]     ic_req_addr_i;
  logic                ic_req_ready_o;
  logic                ic_rsp_valid_o;
  logic [BLK_SIZE-1:0] ic_rsp_data_o;

  logic                dc_req_valid_i;
  logic [XLEN-1:0]     dc_req_addr_i;
  logic                dc_req_rw_i;
  logic [BLK_SIZE-1:0] dc_req_data_i;
  logic                dc_req_uncached_i;
  logic                dc_req_ready_o;
  logic                dc_rsp_valid_o;
  logic [BLK_SIZE-1:0] dc_rsp_data_o;

  logic                mem_req_valid_o;
  logic                mem_req_ready_i;
  logic [XLEN-1:0]     mem_req_addr_o;
  logic                mem_req_rw_o;
  logic [BLK_SIZE-1:0] mem_req_data_o;
  logic                mem_req_uncached_o;
  logic                mem_rsp_valid_i;
  logic [BLK_SIZE-1:0] mem_rsp_data_i;

  logic                busy_o;
  logic                timeout_err_o;

  modport master (
    input  ic_req_valid_i, ic_req_addr_i,
    input  dc_req_valid_i, dc_req_addr_i, dc_req_rw_i, dc_req_data_i, dc_req_uncached_i,
    input  mem_req_ready_i, mem_rsp_valid_i, mem_rsp_data_i,
    output ic_req_ready_o, ic_rsp_valid_o, ic_rsp_data_o,
    output dc_req_ready_o, dc_rsp_valid_o, dc_rsp_data_o,
    output mem_req_valid_o, mem_req_addr_o, mem_req_rw_o, mem_req_data_o, mem_req_uncached_o,
    output busy_o, timeout_err_o
  );

  modport slave (
    output ic_req_valid_i, ic_req_addr_i,
    output dc_req_valid_i, dc_req_addr_i, dc_req_rw_i, dc_req_data_i, dc_req_uncached_i,
    output mem_req_ready_i, mem_rsp_valid_i, mem_rsp_data_i,
    input  ic_req_ready_o, ic_rsp_valid_o, ic_rsp_data_o,
    input  dc_req_ready_o, dc_rsp_valid_o, dc_rsp_data_o,
    input  mem_req_valid_o, mem_req_addr_o, mem_req_rw_o, mem_req_data_o, mem_req_uncached_o,
    input  busy_o, timeout_err_o
  );

endinterface

// File: rtl/lowx_mem_arbiter_rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Combinational two-way round-robin pick between the I-side and D-side.
// Ports:
//   ic_valid_i, dc_valid_i : pending requests
//   last_grant_i           : side granted most recently
//   gnt_valid_o            : some side can be granted
//   gnt_owner_o            : which side wins (the one not granted last on a tie)
// -----------------------------------------------------------------------------
module rr_arb2
  import lowx_mem_arbiter_pkg::*;
(
  input  logic       ic_valid_i,
  input  logic       dc_valid_i,
  input  arb_owner_e last_grant_i,
  output logic       gnt_valid_o,
  output arb_owner_e gnt_owner_o
);

  always_comb begin
    gnt_valid_o = ic_valid_i | dc_valid_i;
    gnt_owner_o = ARB_IC;
    if (ic_valid_i && dc_valid_i) begin
      gnt_owner_o = other_side(last_grant_i);
    end else if (dc_valid_i) begin
      gnt_owner_o = ARB_DC;
    end
  end

endmodule

// File: rtl/lowx_mem_arbiter.sv
// -----------------------------------------------------------------------------
// lowx_mem_arbiter
// Shares one downstream memory port between the I-cache and D-cache miss
// paths. One block-sized transaction is in flight at a time; the owner is
// picked round-robin, the request is latched, issued, and the response is
// routed back as a one-cycle pulse. A watchdog ends a hung transaction with a
// zero-data response and a sticky error flag.
// Ports:
//   clk_i, rst_i : clock, synchronous active-high reset
//   bus          : lowx_mem_arbiter_if.master (ic_*, dc_*, mem_*, busy_o,
//                  timeout_err_o)
// Parameters:
//   XLEN, BLK_SIZE : address / block widths
//   TIMEOUT_CYC    : max cycles in WAIT before the watchdog fires, 0 = off
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ARB_IDLE  | no transaction; the round-robin winner is readied and latched
// ARB_ISSUE | mem_req_valid_o high with latched fields until mem_req_ready_i
// ARB_WAIT  | waiting for mem_rsp_valid_i; watchdog counting
// -----------------------------------------------------------------------------
module lowx_mem_arbiter
  import lowx_mem_arbiter_pkg::*;
#(
  parameter int XLEN        = LOWX_XLEN,
  parameter int BLK_SIZE    = LOWX_BLK_SIZE,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic clk_i,
  input  logic rst_i,
  lowx_mem_arbiter_if.master bus
);

  // Counter only needs to reach TIMEOUT_CYC-1.
  localparam int WDOG_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT_CYC - 1);
  localparam bit WDOG_EN = (TIMEOUT_CYC != 0);

  arb_state_e                 state_q, state_d;
  arb_owner_e                 last_grant_q, last_grant_d;
  lowx_txn_t                  txn_q, txn_d;
  logic [WDOG_W-1:0]          wdog_q, wdog_d;
  logic                       ic_rsp_valid_q, ic_rsp_valid_d;
  logic                       dc_rsp_valid_q, dc_rsp_valid_d;
  logic [LOWX_BLK_SIZE-1:0]   ic_rsp_data_q, ic_rsp_data_d;
  logic [LOWX_BLK_SIZE-1:0]   dc_rsp_data_q, dc_rsp_data_d;
  logic                       timeout_err_q, timeout_err_d;

  logic                       gnt_valid;
  arb_owner_e                 gnt_owner;
  logic                       ic_ready;
  logic                       dc_ready;
  logic                       rsp_fire;
  logic [LOWX_BLK_SIZE-1:0]   rsp_data;

  rr_arb2 u_rr_arb2 (
    .ic_valid_i   (bus.ic_req_valid_i),
    .dc_valid_i   (bus.dc_req_valid_i),
    .last_grant_i (last_grant_q),
    .gnt_valid_o  (gnt_valid),
    .gnt_owner_o  (gnt_owner)
  );

  always_comb begin
    state_d        = state_q;
    last_grant_d   = last_grant_q;
    txn_d          = txn_q;
    wdog_d         = wdog_q;
    ic_rsp_valid_d = 1'b0;
    dc_rsp_valid_d = 1'b0;
    ic_rsp_data_d  = ic_rsp_data_q;
    dc_rsp_data_d  = dc_rsp_data_q;
    timeout_err_d  = timeout_err_q;
    ic_ready       = 1'b0;
    dc_ready       = 1'b0;
    rsp_fire       = 1'b0;
    rsp_data       = '0;

    case (state_q)
      ARB_IDLE: begin
        // Gated by rst_i so no handshake completes in a reset cycle.
        if (gnt_valid && !rst_i) begin
          state_d      = ARB_ISSUE;
          last_grant_d = gnt_owner;
          txn_d.owner  = gnt_owner;
          if (gnt_owner == ARB_IC) begin
            ic_ready       = 1'b1;
            txn_d.addr     = bus.ic_req_addr_i;
            txn_d.rw       = 1'b0;
            txn_d.data     = '0;
            txn_d.uncached = 1'b0;
          end else begin
            dc_ready       = 1'b1;
            txn_d.addr     = bus.dc_req_addr_i;
            txn_d.rw       = bus.dc_req_rw_i;
            txn_d.data     = bus.dc_req_data_i;
            txn_d.uncached = bus.dc_req_uncached_i;
          end
        end
      end

      ARB_ISSUE: begin
        if (bus.mem_req_ready_i) begin
          state_d = ARB_WAIT;
          wdog_d  = '0;
        end
      end

      ARB_WAIT: begin
        wdog_d = wdog_q + WDOG_W'(1);
        if (bus.mem_rsp_valid_i) begin
          state_d  = ARB_IDLE;
          rsp_fire = 1'b1;
          rsp_data = txn_q.rw ? '0 : bus.mem_rsp_data_i;
        end else if (WDOG_EN && (wdog_q == WDOG_LAST)) begin
          state_d       = ARB_IDLE;
          rsp_fire      = 1'b1;
          rsp_data      = '0;
          timeout_err_d = 1'b1;
        end
      end

      default: state_d = ARB_IDLE;
    endcase

    // The non-owner's data register is left untouched.
    if (rsp_fire) begin
      if (txn_q.owner == ARB_IC) begin
        ic_rsp_valid_d = 1'b1;
        ic_rsp_data_d  = rsp_data;
      end else begin
        dc_rsp_valid_d = 1'b1;
        dc_rsp_data_d  = rsp_data;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= ARB_IDLE;
      last_grant_q   <= ARB_IC;
      txn_q          <= '0;
      wdog_q         <= '0;
      ic_rsp_valid_q <= 1'b0;
      dc_rsp_valid_q <= 1'b0;
      ic_rsp_data_q  <= '0;
      dc_rsp_data_q  <= '0;
      timeout_err_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      last_grant_q   <= last_grant_d;
      txn_q          <= txn_d;
      wdog_q         <= wdog_d;
      ic_rsp_valid_q <= ic_rsp_valid_d;
      dc_rsp_valid_q <= dc_rsp_valid_d;
      ic_rsp_data_q  <= ic_rsp_data_d;
      dc_rsp_data_q  <= dc_rsp_data_d;
      timeout_err_q  <= timeout_err_d;
    end
  end

  assign bus.ic_req_ready_o     = ic_ready;
  assign bus.dc_req_ready_o     = dc_ready;
  assign bus.ic_rsp_valid_o     = ic_rsp_valid_q;
  assign bus.dc_rsp_valid_o     = dc_rsp_valid_q;
  assign bus.ic_rsp_data_o      = BLK_SIZE'(ic_rsp_data_q);
  assign bus.dc_rsp_data_o      = BLK_SIZE'(dc_rsp_data_q);
  assign bus.mem_req_valid_o    = (state_q == ARB_ISSUE);
  assign bus.mem_req_addr_o     = XLEN'(txn_q.addr);
  assign bus.mem_req_rw_o       = txn_q.rw;
  assign bus.mem_req_data_o     = BLK_SIZE'(txn_q.data);
  assign bus.mem_req_uncached_o = txn_q.uncached;
  assign bus.busy_o             = (state_q != ARB_IDLE);
  assign bus.timeout_err_o      = timeout_err_q;

endmodule

// File: tb/tb_lowx_mem_arbiter.sv
module tb_lowx_mem_arbiter;

  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lowx_mem_arbiter_if #(.XLEN(32), .BLK_SIZE(128)) bus();

  lowx_mem_arbiter #(.XLEN(32), .BLK_SIZE(128), .TIMEOUT_CYC(TO)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b required=%b t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic chkv(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Transaction-level reference model. Holds the one open transaction (if any),
  // whether memory took the request, how many cycles it has waited, and the
  // response pulses due next cycle. Checked at every negedge, then advanced to
  // what must hold after the coming posedge.
  // ---------------------------------------------------------------------------
  bit           m_live = 0;
  bit           m_open, m_acc, m_last, m_owner, m_rw, m_unc;
  bit           m_icp, m_dcp, m_err;
  logic [31:0]  m_addr;
  logic [127:0] m_data, m_icd, m_dcd;
  int           m_waited;

  always @(negedge clk) begin : model
    bit ic_v, dc_v, e_icr, e_dcr;
    ic_v  = bus.ic_req_valid_i;
    dc_v  = bus.dc_req_valid_i;
    // Tie goes to the side not granted last (m_last: 0 = IC, 1 = DC).
    e_icr = !rst && !m_open && ic_v && (!dc_v || m_last);
    e_dcr = !rst && !m_open && dc_v && (!ic_v || !m_last);
    if (m_live) begin
      chk1("ic_req_ready", bus.ic_req_ready_o, e_icr);
      chk1("dc_req_ready", bus.dc_req_ready_o, e_dcr);
      chk1("mem_req_valid", bus.mem_req_valid_o, m_open && !m_acc);
      if (m_open && !m_acc) begin
        chkv("mem_req_addr", 128'(bus.mem_req_addr_o), 128'(m_addr));
        chk1("mem_req_rw", bus.mem_req_rw_o, m_rw);
        chkv("mem_req_data", bus.mem_req_data_o, m_data);
        chk1("mem_req_uncached", bus.mem_req_uncached_o, m_unc);
      end
      chk1("busy", bus.busy_o, m_open);
      chk1("ic_rsp_valid", bus.ic_rsp_valid_o, m_icp);
      chk1("dc_rsp_valid", bus.dc_rsp_valid_o, m_dcp);
      chkv("ic_rsp_data", bus.ic_rsp_data_o, m_icd);
      chkv("dc_rsp_data", bus.dc_rsp_data_o, m_dcd);
      chk1("timeout_err", bus.timeout_err_o, m_err);
    end
    if (rst) begin
      m_live = 1; m_open = 0; m_acc = 0; m_last = 0;
      m_icp = 0; m_dcp = 0; m_icd = '0; m_dcd = '0; m_err = 0;
    end else if (m_live) begin
      m_icp = 0; m_dcp = 0;
      if (!m_open) begin
        if (e_icr) begin
          m_open = 1; m_acc = 0; m_owner = 0; m_last = 0;
          m_addr = bus.ic_req_addr_i; m_rw = 0; m_data = '0; m_unc = 0;
        end else if (e_dcr) begin
          m_open = 1; m_acc = 0; m_owner = 1; m_last = 1;
          m_addr = bus.dc_req_addr_i; m_rw = bus.dc_req_rw_i;
          m_data = bus.dc_req_data_i; m_unc = bus.dc_req_uncached_i;
        end
      end else if (!m_acc) begin
        if (bus.mem_req_ready_i) begin m_acc = 1; m_waited = 0; end
      end else begin
        m_waited++;  // this cycle is WAIT cycle number m_waited
        if (bus.mem_rsp_valid_i || m_waited == TO) begin
          logic [127:0] d;
          d = (bus.mem_rsp_valid_i && !m_rw) ? bus.mem_rsp_data_i : '0;
          if (!bus.mem_rsp_valid_i) m_err = 1;
          if (m_owner) begin m_dcp = 1; m_dcd = d; end
          else         begin m_icp = 1; m_icd = d; end
          m_open = 0; m_acc = 0;
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic clr_inputs();
    bus.ic_req_valid_i = 0; bus.ic_req_addr_i = '0;
    bus.dc_req_valid_i = 0; bus.dc_req_addr_i = '0; bus.dc_req_rw_i = 0;
    bus.dc_req_data_i = '0; bus.dc_req_uncached_i = 0;
    bus.mem_req_ready_i = 0; bus.mem_rsp_valid_i = 0; bus.mem_rsp_data_i = '0;
  endtask

  task automatic do_reset();
    rst = 1;
    clr_inputs();
    cyc(); cyc();
    @(negedge clk);
    chk1("rst_ic_ready", bus.ic_req_ready_o, 1'b0);
    chk1("rst_dc_ready", bus.dc_req_ready_o, 1'b0);
    chk1("rst_ic_rsp_valid", bus.ic_rsp_valid_o, 1'b0);
    chk1("rst_dc_rsp_valid", bus.dc_rsp_valid_o, 1'b0);
    chkv("rst_ic_rsp_data", bus.ic_rsp_data_o, '0);
    chkv("rst_dc_rsp_data", bus.dc_rsp_data_o, '0);
    chk1("rst_mem_req_valid", bus.mem_req_valid_o, 1'b0);
    chkv("rst_mem_req_addr", 128'(bus.mem_req_addr_o), '0);
    chkv("rst_mem_req_data", bus.mem_req_data_o, '0);
    chk1("rst_mem_req_rw", bus.mem_req_rw_o, 1'b0);
    chk1("rst_mem_req_uncached", bus.mem_req_uncached_o, 1'b0);
    chk1("rst_busy", bus.busy_o, 1'b0);
    chk1("rst_timeout_err", bus.timeout_err_o, 1'b0);
    cyc();
    rst = 0;
  endtask

  initial begin : guard
    #1_000_000;
    $display("FAIL tb_time_limit actual=expired required=finish");
    $fatal(1, "time limit");
  end

  initial begin : driver
    logic [127:0] a5;
    int n, dc_pulses;
    bit seen_ic;
    bit order [3];
    bit ic_fire, dc_fire;
    a5 = {16{8'hA5}};
    clr_inputs();
    do_reset();

    // IC-only read, accepted at once, answered in the 4th WAIT cycle.
    bus.ic_req_valid_i = 1; bus.ic_req_addr_i = 32'h8000_0040; bus.mem_req_ready_i = 1;
    @(negedge clk); chk1("t1_ic_ready_T", bus.ic_req_ready_o, 1'b1);
    cyc(); bus.ic_req_valid_i = 0;
    @(negedge clk);
    chk1("t1_mem_valid_T1", bus.mem_req_valid_o, 1'b1);
    chkv("t1_mem_addr", 128'(bus.mem_req_addr_o), 128'(32'h8000_0040));
    chk1("t1_mem_rw", bus.mem_req_rw_o, 1'b0);
    cyc(); bus.mem_req_ready_i = 0;
    cyc(); cyc(); cyc();
    bus.mem_rsp_valid_i = 1; bus.mem_rsp_data_i = a5;
    cyc(); bus.mem_rsp_valid_i = 0;
    @(negedge clk);
    chk1("t1_ic_rsp_valid", bus.ic_rsp_valid_o, 1'b1);
    chkv("t1_ic_rsp_data", bus.ic_rsp_data_o, a5);
    chk1("t1_dc_rsp_valid", bus.dc_rsp_valid_o, 1'b0);
    cyc();
    @(negedge clk); chk1("t1_ic_rsp_one_cycle", bus.ic_rsp_valid_o, 1'b0);

    // Both sides held after reset: DC, IC, DC.
    do_reset();
    bus.ic_req_valid_i = 1; bus.ic_req_addr_i = 32'h0000_0100;
    bus.dc_req_valid_i = 1; bus.dc_req_addr_i = 32'h0000_0200;
    bus.mem_req_ready_i = 1; bus.mem_rsp_valid_i = 1; bus.mem_rsp_data_i = a5;
    n = 0; dc_pulses = 0; seen_ic = 0;
    for (int c = 0; c < 40 && n < 3; c++) begin
      @(negedge clk);
      if (bus.dc_rsp_valid_o) dc_pulses++;
      if (bus.dc_req_ready_o) begin order[n] = 1; n++; end
      else if (bus.ic_req_ready_o) begin
        if (!seen_ic) chkv("t2_ic_first_after_dc_rsp", 128'(dc_pulses), 128'(1));
        seen_ic = 1; order[n] = 0; n++;
      end
      cyc();
    end
    chkv("t2_grant_count", 128'(n), 128'(3));
    chk1("t2_grant0_dc", order[0], 1'b1);
    chk1("t2_grant1_ic", order[1], 1'b0);
    chk1("t2_grant2_dc", order[2], 1'b1);

    // Uncached DC write, memory stalls 4 cycles, IC waiting meanwhile.
    do_reset();
    bus.dc_req_valid_i = 1; bus.dc_req_addr_i = 32'h1000_0000; bus.dc_req_rw_i = 1;
    bus.dc_req_uncached_i = 1; bus.dc_req_data_i = 128'h1234;
    bus.ic_req_valid_i = 1; bus.ic_req_addr_i = 32'h2000_0000;
    @(negedge clk);
    chk1("t3_dc_ready", bus.dc_req_ready_o, 1'b1);
    chk1("t3_ic_not_ready", bus.ic_req_ready_o, 1'b0);
    cyc(); bus.dc_req_valid_i = 0;
    for (int i = 0; i < 5; i++) begin
      bus.mem_req_ready_i = (i == 4);
      @(negedge clk);
      chk1("t3_mem_valid_held", bus.mem_req_valid_o, 1'b1);
      chkv("t3_mem_addr", 128'(bus.mem_req_addr_o), 128'(32'h1000_0000));
      chk1("t3_mem_rw", bus.mem_req_rw_o, 1'b1);
      chk1("t3_mem_uncached", bus.mem_req_uncached_o, 1'b1);
      chkv("t3_mem_data", bus.mem_req_data_o, 128'h1234);
      chk1("t3_no_ic_grant_busy", bus.ic_req_ready_o, 1'b0);
      cyc();
    end
    bus.mem_rsp_valid_i = 1; bus.mem_rsp_data_i = 128'hDEAD_BEEF;
    cyc(); bus.mem_rsp_valid_i = 0;
    @(negedge clk);
    chk1("t3_dc_rsp_valid", bus.dc_rsp_valid_o, 1'b1);
    chkv("t3_dc_rsp_data_zero", bus.dc_rsp_data_o, '0);
    chk1("t3_ic_rsp_quiet", bus.ic_rsp_valid_o, 1'b0);

    // Watchdog: no response ever.
    do_reset();
    bus.ic_req_valid_i = 1; bus.ic_req_addr_i = 32'h0000_4000; bus.mem_req_ready_i = 1;
    @(negedge clk); chk1("t4_ic_ready", bus.ic_req_ready_o, 1'b1);
    cyc(); bus.ic_req_valid_i = 0;
    cyc();
    for (int k = 0; k < TO; k++) begin
      @(negedge clk); chk1("t4_no_early_rsp", bus.ic_rsp_valid_o, 1'b0);
      cyc();
    end
    @(negedge clk);
    chk1("t4_timeout_rsp", bus.ic_rsp_valid_o, 1'b1);
    chkv("t4_timeout_data", bus.ic_rsp_data_o, '0);
    chk1("t4_timeout_err", bus.timeout_err_o, 1'b1);
    repeat (5) cyc();
    @(negedge clk);
    chk1("t4_err_sticky", bus.timeout_err_o, 1'b1);
    chk1("t4_idle", bus.busy_o, 1'b0);

    // Reset in WAIT, then a late memory response.
    do_reset();
    bus.ic_req_valid_i = 1; bus.ic_req_addr_i = 32'h0000_8000; bus.mem_req_ready_i = 1;
    @(negedge clk); chk1("t5_ic_ready", bus.ic_req_ready_o, 1'b1);
    cyc(); bus.ic_req_valid_i = 0;
    cyc(); cyc();
    rst = 1;
    cyc(); rst = 0;
    bus.mem_rsp_valid_i = 1; bus.mem_rsp_data_i = a5;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk1("t5_no_late_rsp", bus.ic_rsp_valid_o, 1'b0);
      chk1("t5_idle", bus.busy_o, 1'b0);
      cyc();
    end
    bus.mem_rsp_valid_i = 0;
    bus.ic_req_valid_i = 1; bus.dc_req_valid_i = 1;
    @(negedge clk);
    chk1("t5_last_ic_dc_wins", bus.dc_req_ready_o, 1'b1);
    chk1("t5_last_ic_ic_waits", bus.ic_req_ready_o, 1'b0);

    // Randomised traffic against the model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      ic_fire = bus.ic_req_valid_i && bus.ic_req_ready_o;
      dc_fire = bus.dc_req_valid_i && bus.dc_req_ready_o;
      cyc();
      rst = ($urandom_range(0, 499) == 0);
      if (ic_fire) bus.ic_req_valid_i = 0;
      if (dc_fire) bus.dc_req_valid_i = 0;
      if (!bus.ic_req_valid_i && $urandom_range(0, 99) < 40) begin
        bus.ic_req_valid_i = 1;
        bus.ic_req_addr_i  = $urandom & 32'hFFFF_FFC0;
      end
      if (!bus.dc_req_valid_i && $urandom_range(0, 99) < 40) begin
        bus.dc_req_valid_i    = 1;
        bus.dc_req_addr_i     = $urandom & 32'hFFFF_FFC0;
        bus.dc_req_rw_i       = $urandom_range(0, 1);
        bus.dc_req_uncached_i = $urandom_range(0, 1);
        bus.dc_req_data_i     = {$urandom, $urandom, $urandom, $urandom};
      end
      bus.mem_req_ready_i = ($urandom_range(0, 9) < 6);
      bus.mem_rsp_valid_i = ($urandom_range(0, 99) < 15);
      bus.mem_rsp_data_i  = {$urandom, $urandom, $urandom, $urandom};
    end
    clr_inputs();
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
